// File: rtl/percept_feeder.sv
// ----------------------------------------------------------------------------
// percept_feeder
//
// Sequences a dot product through an external multiplier cell. Terms
// (input, weight) arrive on a valid/ready stream. Each term is registered,
// written into the cell for one cycle, given one cycle to produce its product,
// and the product is then added to an unsigned accumulator. After the last
// term the accumulator is published on result and compared against threshold
// to produce fire.
//
// Term-stream handshake: a term is transferred on a rising edge where
// ld_valid and ld_ready are both 1. ld_ready is 1 only in FETCH and is held
// low in a cycle where abort is high, so an aborted run never swallows a term.
// ld_ready does not depend on ld_valid.
//
// Ports
//   clk, nRst         clock, asynchronous active-low reset
//   start, len        begin a dot product of len (0..15) terms (IDLE only)
//   ld_valid/ld_ready term stream handshake; ld_in, ld_weight term operands
//   threshold         fire = (final accumulator >= threshold), unsigned
//   abort             synchronous cancel back to IDLE, no done pulse
//   p_write/p_in/p_weight  write side of the multiplier cell
//   p_out             product returned by the multiplier cell
//   result, fire      held from one DONE to the next
//   done              one-cycle pulse while in DONE
//   busy              high in every state except IDLE
//   dbg_state_o       current FSM state, for debug and checkers
//
// Configuration
//   PERCEPT_FEEDER_BIAS_EN  when defined, adds a 16-bit bias input whose
//                           zero-extended value preloads the accumulator at
//                           start; otherwise the accumulator starts at 0.
// ----------------------------------------------------------------------------
module percept_feeder #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             ld_valid,
    input  logic [7:0]       ld_in,
    input  logic [7:0]       ld_weight,
    output logic             ld_ready,
    input  logic [ACC_W-1:0] threshold,
    input  logic             abort,
`ifdef PERCEPT_FEEDER_BIAS_EN
    input  logic [15:0]      bias,
`endif
    output logic             p_write,
    output logic [7:0]       p_in,
    output logic [7:0]       p_weight,
    input  logic [15:0]      p_out,
    output logic [ACC_W-1:0] result,
    output logic             fire,
    output logic             done,
    output logic             busy,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         len_q, len_d;
    logic [7:0]         p_in_q, p_in_d;
    logic [7:0]         p_weight_q, p_weight_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               fire_q, fire_d;

    logic [ACC_W-1:0]   acc_init;
    logic [ACC_W-1:0]   prod_ext;

`ifdef PERCEPT_FEEDER_BIAS_EN
    assign acc_init = {{(ACC_W-16){1'b0}}, bias};
`else
    assign acc_init = '0;
`endif

    assign prod_ext = {{(ACC_W-16){1'b0}}, p_out};

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        p_in_d     = p_in_q;
        p_weight_d = p_weight_q;
        result_d   = result_q;
        fire_d     = fire_q;

        if (abort && (state_q != IDLE)) begin
            // Cancel wins over everything; result and fire keep their values.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d   = acc_init;
                        cnt_d   = 4'd0;
                        // len is captured so a change on the pin mid-run
                        // cannot alter the term count.
                        len_d   = len;
                        state_d = (len == 4'd0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (ld_valid) begin
                        p_in_d     = ld_in;
                        p_weight_d = ld_weight;
                        state_d    = ISSUE;
                    end
                end
                ISSUE:   state_d = WAIT;
                WAIT:    state_d = CAPTURE;
                CAPTURE: begin
                    acc_d   = acc_q + prod_ext;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == (len_q - 4'd1)) ? DONE : FETCH;
                end
                DONE: begin
                    result_d = acc_q;
                    fire_d   = (acc_q >= threshold);
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= 4'd0;
            len_q      <= 4'd0;
            p_in_q     <= 8'd0;
            p_weight_q <= 8'd0;
            result_q   <= '0;
            fire_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            p_in_q     <= p_in_d;
            p_weight_q <= p_weight_d;
            result_q   <= result_d;
            fire_q     <= fire_d;
        end
    end

    // Write strobe is a pure state decode: exactly one cycle per term, and it
    // drops immediately when abort moves the FSM out of ISSUE.
    assign p_write     = (state_q == ISSUE);
    assign p_in        = p_in_q;
    assign p_weight    = p_weight_q;
    assign ld_ready    = (state_q == FETCH) && !abort;
    assign done        = (state_q == DONE) && !abort;
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign fire        = fire_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_percept_feeder.sv
// ----------------------------------------------------------------------------
// tb_percept_feeder
//
// Bench for percept_feeder. Contains a behavioural multiplier cell (latches
// operands while write=1, registers the product on the edge after write has
// returned to 0). The driver issues dot products and pushes the expected
// result, fire and done cycle into queues; a monitor pops them whenever done
// is seen. Expected values come from plain arithmetic on the term list.
// Define PERCEPT_FEEDER_BIAS_EN for both files to exercise the bias build.
// ----------------------------------------------------------------------------
module tb_percept_feeder;

  localparam int ACC_W = 20;

`ifdef PERCEPT_FEEDER_BIAS_EN
  localparam int BIAS_V = 1000;
  logic [15:0] bias = 16'd1000;
`else
  localparam int BIAS_V = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             start = 1'b0;
  logic [3:0]       len = 4'd0;
  logic             ld_valid = 1'b0;
  logic [7:0]       ld_in = 8'd0;
  logic [7:0]       ld_weight = 8'd0;
  logic             ld_ready;
  logic [ACC_W-1:0] threshold = '0;
  logic             abort = 1'b0;
  logic             p_write;
  logic [7:0]       p_in;
  logic [7:0]       p_weight;
  logic [15:0]      p_out = 16'd0;
  logic [ACC_W-1:0] result;
  logic             fire;
  logic             done;
  logic             busy;
  logic [2:0]       dbg_state;

  percept_feeder #(.ACC_W(ACC_W)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .start       (start),
    .len         (len),
    .ld_valid    (ld_valid),
    .ld_in       (ld_in),
    .ld_weight   (ld_weight),
    .ld_ready    (ld_ready),
    .threshold   (threshold),
    .abort       (abort),
`ifdef PERCEPT_FEEDER_BIAS_EN
    .bias        (bias),
`endif
    .p_write     (p_write),
    .p_in        (p_in),
    .p_weight    (p_weight),
    .p_out       (p_out),
    .result      (result),
    .fire        (fire),
    .done        (done),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- behavioural multiplier cell ----------------
  logic [7:0] cell_a = 8'd0;
  logic [7:0] cell_b = 8'd0;
  logic       cell_pend = 1'b0;
  always @(posedge clk) begin
    if (p_write) begin
      cell_a    <= p_in;
      cell_b    <= p_weight;
      cell_pend <= 1'b1;
    end else if (cell_pend) begin
      p_out     <= 16'(cell_a) * 16'(cell_b);
      cell_pend <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_p_write"}, p_write, 0);
    chk({tag, "_p_in"}, p_in, 0);
    chk({tag, "_p_weight"}, p_weight, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_fire"}, fire, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [ACC_W-1:0] exp_q[$];
  logic             exp_fire_q[$];
  int               exp_cyc_q[$];

  logic [ACC_W-1:0] mon_res;
  logic             mon_fire;
  bit               mon_pend = 0;
  int               pw_cnt = 0;

  always @(negedge clk) begin
    if (p_write === 1'b1) pw_cnt++;
    if (mon_pend) begin
      chk("result", result, mon_res);
      chk("fire", fire, mon_fire);
      mon_pend = 0;
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: actual done=1 at cycle %0d, required no done", cyc);
      end else begin
        mon_res  = exp_q.pop_front();
        mon_fire = exp_fire_q.pop_front();
        chk("done_cycle", cyc, exp_cyc_q.pop_front());
        mon_pend = 1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]       ta[16];
  logic [7:0]       tb[16];
  logic [ACC_W-1:0] last_res = '0;
  logic             last_fire = 1'b0;

  // Dot product of the first n terms plus bias, reduced modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] model_acc(input int n);
    longint sum;
    sum = BIAS_V;
    for (int i = 0; i < n; i++) sum += longint'(ta[i]) * longint'(tb[i]);
    return ACC_W'(sum);
  endfunction

  // ---------------- driver ----------------
  // mode: 0 = run to completion, 1 = abort at start_cycle+ev_rel,
  //       2 = reset pulse at start_cycle+ev_rel.
  // stall_term: term index whose FETCH sees ld_valid low for stall_len cycles
  // (any value >= n means no stall).
  task automatic run_op(input int n, input logic [ACC_W-1:0] thr, input int mode,
                        input int ev_rel, input int stall_term, input int stall_len,
                        input bit busy_start);
    logic [ACC_W-1:0] m_res;
    logic             m_fire;
    int s, k, gap, ev_c, c_end, pw0, extra;
    bit ended, stopped;

    m_res  = model_acc(n);
    m_fire = (m_res >= thr);
    extra  = (stall_term < n) ? stall_len : 0;

    @(negedge clk);
    threshold = thr;
    len       = 4'(n);
    start     = 1'b1;
    s         = cyc + 1;
    pw0       = pw_cnt;
    if (mode == 0) begin
      exp_q.push_back(m_res);
      exp_fire_q.push_back(m_fire);
      exp_cyc_q.push_back(s + 4 * n + extra);
      last_res  = m_res;
      last_fire = m_fire;
    end

    k = 0; gap = 0; ev_c = -1; c_end = -1; ended = 0; stopped = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = busy_start && (c == 0);
      if (busy_start && (c == 0)) len = 4'd5;
      abort = (mode == 1) && (cyc == s + ev_rel);
      if ((mode == 2) && (cyc == s + ev_rel)) nRst = 1'b0;
      ld_valid = 1'b0;
      #1;
      if ((mode == 2) && !nRst) begin
        check_reset("mid_reset");
        ev_c = c; c_end = c; ended = 1;
        break;
      end
      if (!busy) begin
        c_end = c; ended = 1;
        break;
      end
      if (!stopped && (k < n)) begin
        if ((k == stall_term) && (gap < stall_len)) begin
          if (gap > 0) chk("stall_ready", ld_ready, 1);
          if (ld_ready || (gap > 0)) gap++;
        end else begin
          ld_valid  = 1'b1;
          ld_in     = ta[k];
          ld_weight = tb[k];
          if (ld_ready) k++;
        end
      end
      if (abort) begin
        stopped = 1;
        ev_c = c;
      end
    end

    abort = 1'b0;
    ld_valid = 1'b0;
    start = 1'b0;
    if (!ended) begin
      total++;
      bad++;
      $display("FAIL op_timeout: actual busy after 400 cycles, required return to idle (len=%0d)", n);
    end
    if (mode == 1) chk("abort_to_idle", c_end - ev_c, 1);
    if (mode == 2) begin
      @(negedge clk);
      nRst = 1'b1;
      last_res = '0;
      last_fire = 1'b0;
    end
    if (mode != 0) begin
      chk("held_result", result, last_res);
      chk("held_fire", fire, last_fire);
    end
    chk("pwrite_pulses", pw_cnt - pw0, k);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      ta[i] = 8'($urandom_range(0, 255));
      tb[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, pick, st;
    logic [ACC_W-1:0] m, thr;

    nRst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    // Three small terms: 6 + 20 + 100.
    ta[0] = 8'd2;  tb[0] = 8'd3;
    ta[1] = 8'd4;  tb[1] = 8'd5;
    ta[2] = 8'd10; tb[2] = 8'd10;
    run_op(3, ACC_W'(100), 0, 0, 16, 0, 0);

    // Full-length run with maximal operands, threshold one above the sum.
    for (int i = 0; i < 15; i++) begin ta[i] = 8'd255; tb[i] = 8'd255; end
    run_op(15, ACC_W'(975376), 0, 0, 16, 0, 0);

    // Five-cycle stall before the second term.
    fill_random(2);
    run_op(2, ACC_W'(50000), 0, 0, 1, 5, 0);

    // Abort in WAIT of the second term, then a normal run.
    fill_random(4);
    run_op(4, ACC_W'(0), 1, 6, 16, 0, 0);
    run_op(4, model_acc(4), 0, 0, 16, 0, 0);

    // Abort in ISSUE of the second term, then a normal run.
    fill_random(3);
    run_op(3, ACC_W'(0), 1, 5, 16, 0, 0);
    run_op(3, model_acc(3) + 1, 0, 0, 16, 0, 0);

    // Empty dot product, with a start pulse while busy.
    run_op(0, ACC_W'(0), 0, 0, 16, 0, 1);

    // Reset pulse in CAPTURE of the first term, then a normal run.
    fill_random(2);
    run_op(2, ACC_W'(0), 2, 3, 16, 0, 0);
    fill_random(3);
    run_op(3, ACC_W'(1000), 0, 0, 16, 0, 0);

    // Single term (10,10).
    ta[0] = 8'd10; tb[0] = 8'd10;
    run_op(1, ACC_W'(0), 0, 0, 16, 0, 0);

    // Randomised runs with thresholds clustered around the sum.
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 15);
      fill_random(n);
      m = model_acc(n);
      pick = $urandom_range(0, 3);
      case (pick)
        0: thr = (m == '0) ? '0 : m - 1;
        1: thr = m;
        2: thr = m + 1;
        default: thr = ACC_W'($urandom_range(0, (1 << ACC_W) - 1));
      endcase
      st = $urandom_range(0, 16);
      run_op(n, thr, 0, 0, st, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: actual simulation still running at 500000ns, required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
